// File: rtl/accum_feeder_pkg.sv
// Shared types and default sizing for the accumulator feeder.
package accum_feeder_pkg;

  localparam int unsigned W_DEF   = 32;
  localparam int unsigned LEN_DEF = 8;
  localparam int unsigned LAT_DEF = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    HOLD   = 2'd3
  } state_e;

endpackage

// File: rtl/accum_feeder_if.sv
// Operand stream, accumulator drive and result stream of accum_feeder.
// slave = feeder side, master = environment (source, accumulator, sink).
interface accum_feeder_if
  import accum_feeder_pkg::*;
#(
  parameter int W = W_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;

  logic [W-1:0]     acc_a;
  logic [W-1:0]     acc_b;
  logic             acc_clken;
  logic             acc_sload;
  logic [2*W-1:0]   acc_sum;

  logic             res_valid;
  logic             res_ready;
  logic [2*W-1:0]   res_data;

  modport slave (
    input  in_valid, in_last, in_a, in_b, acc_sum, res_ready,
    output in_ready, acc_a, acc_b, acc_clken, acc_sload, res_valid, res_data
  );

  modport master (
    output in_valid, in_last, in_a, in_b, acc_sum, res_ready,
    input  in_ready, acc_a, acc_b, acc_clken, acc_sload, res_valid, res_data
  );

endinterface

// File: rtl/accum_feeder.sv
// Feeds operand pairs into an external LAT-cycle multiply-accumulator and
// returns one dot-product per vector. ACCUM_FEEDER_LAST_EN: in_last ends a vector early.
//
// state  | meaning
// IDLE   | waiting for element 0 of a new vector
// STREAM | elements 1..LEN-1 being accepted
// DRAIN  | waiting LAT cycles for the accumulator to settle
// HOLD   | result presented until res_ready
module accum_feeder
  import accum_feeder_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int LEN = LEN_DEF,
  parameter int LAT = LAT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  accum_feeder_if.slave  bus
);

  localparam int CW = $clog2(LEN + 1);
  localparam int DW = $clog2(LAT + 1);
  localparam logic [CW-1:0] LAST_IDX   = CW'(LEN - 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(LAT - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     drn_q, drn_d;
  logic              res_valid_q, res_valid_d;
  logic [2*W-1:0]    res_data_q, res_data_d;

  logic              in_ready;
  logic              xfer;
  logic              end_vec;

  always_comb begin
    in_ready = !rst && ((state_q == IDLE) || (state_q == STREAM));
    xfer     = bus.in_valid && in_ready;
`ifdef ACCUM_FEEDER_LAST_EN
    end_vec  = xfer && (bus.in_last || (cnt_q == LAST_IDX));
`else
    end_vec  = xfer && (cnt_q == LAST_IDX);
`endif
  end

`ifndef ACCUM_FEEDER_LAST_EN
  logic unused_in_last;
  assign unused_in_last = bus.in_last;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    drn_d       = drn_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    case (state_q)
      IDLE, STREAM: begin
        if (end_vec) begin
          state_d = DRAIN;
          cnt_d   = '0;
          drn_d   = DRAIN_LOAD;
        end else if (xfer) begin
          state_d = STREAM;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        // drn_q reaching zero marks the edge LAT cycles after the last operand
        if (drn_q == '0) begin
          state_d     = HOLD;
          res_valid_d = 1'b1;
          res_data_d  = bus.acc_sum;
        end else begin
          drn_d = drn_q - DW'(1);
        end
      end
      HOLD: begin
        if (bus.res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      drn_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drn_q       <= drn_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  // Zero operands outside transfers so bubbles add nothing to the running sum
  assign bus.in_ready  = in_ready;
  assign bus.acc_a     = xfer ? bus.in_a : '0;
  assign bus.acc_b     = xfer ? bus.in_b : '0;
  assign bus.acc_sload = xfer && (cnt_q == '0);
  assign bus.acc_clken = !rst;
  assign bus.res_valid = res_valid_q && !rst;
  assign bus.res_data  = rst ? '0 : res_data_q;

endmodule

// File: tb/tb_accum_feeder.sv
// Self-checking bench for accum_feeder with a LAT-cycle sum-of-products accumulator model.
module tb_accum_feeder;

  localparam int W   = 32;
  localparam int LEN = 4;
  localparam int LAT = 2;
`ifdef ACCUM_FEEDER_LAST_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  typedef logic [LEN-1:0][W-1:0] vec_w_t;

  typedef struct {
    vec_w_t         a;
    vec_w_t         b;
    int             gap;
    int             hold;
    int             last_idx;
    logic [2*W-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  accum_feeder_if #(.W(W)) f0 ();
  accum_feeder_if #(.W(W)) f1 ();

  accum_feeder #(.W(W), .LEN(LEN), .LAT(LAT)) u_dut0 (.clk(clk), .rst(rst), .bus(f0));
  accum_feeder #(.W(W), .LEN(1),   .LAT(LAT)) u_dut1 (.clk(clk), .rst(rst), .bus(f1));

  function automatic logic [2*W-1:0] mul(input logic [W-1:0] a, input logic [W-1:0] b);
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  // Accumulator model: running total in pipe[0], delayed so acc_sum settles LAT edges after sampling
  logic [2*W-1:0] pipe0 [LAT];
  logic [2*W-1:0] pipe1 [LAT];
  always @(posedge clk) begin
    if (f0.acc_clken) begin
      pipe0[0] <= f0.acc_sload ? mul(f0.acc_a, f0.acc_b) : pipe0[0] + mul(f0.acc_a, f0.acc_b);
      for (int i = 1; i < LAT; i++) pipe0[i] <= pipe0[i-1];
    end
    if (f1.acc_clken) begin
      pipe1[0] <= f1.acc_sload ? mul(f1.acc_a, f1.acc_b) : pipe1[0] + mul(f1.acc_a, f1.acc_b);
      for (int i = 1; i < LAT; i++) pipe1[i] <= pipe1[i-1];
    end
  end
  assign f0.acc_sum = pipe0[LAT-1];
  assign f1.acc_sum = pipe1[LAT-1];

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] dot(input vec_w_t va, input vec_w_t vb, input int nel);
    logic [2*W-1:0] s = '0;
    for (int i = 0; i < nel; i++) s += mul(va[i], vb[i]);
    return s;
  endfunction

  function automatic int n_elems(input int last_idx);
    return (LAST_EN && last_idx >= 0) ? last_idx + 1 : LEN;
  endfunction

  task automatic wait_result(input string nm, input logic [2*W-1:0] exp, input bit use_f1);
    int k = 0;
    while (!(use_f1 ? f1.res_valid : f0.res_valid) && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chkw({nm, "_latency"}, 64'(k), 64'(LAT));
    chkw({nm, "_data"}, use_f1 ? f1.res_data : f0.res_data, exp);
  endtask

  task automatic run_vec(input string nm, input vec_w_t va, input vec_w_t vb, input int gap,
                         input int hold, input int last_idx, input logic [2*W-1:0] exp);
    int nel = n_elems(last_idx);
    f0.res_ready = (hold == 0);
    for (int i = 0; i < nel; i++) begin
      if (i > 0) begin
        repeat (gap) begin
          @(negedge clk);
          f0.in_valid = 1'b0; f0.in_last = 1'b0;
          #1;
          chk1({nm, "_gap_ready"}, f0.in_ready, 1'b1);
          chkw({nm, "_gap_acc_a"}, 64'(f0.acc_a), 64'd0);
          chk1({nm, "_gap_sload"}, f0.acc_sload, 1'b0);
        end
      end
      @(negedge clk);
      f0.in_valid = 1'b1; f0.in_a = va[i]; f0.in_b = vb[i]; f0.in_last = (i == last_idx);
      #1;
      chk1({nm, "_ready"}, f0.in_ready, 1'b1);
      chkw({nm, "_acc_a"}, 64'(f0.acc_a), 64'(va[i]));
      chkw({nm, "_acc_b"}, 64'(f0.acc_b), 64'(vb[i]));
      chk1({nm, "_sload"}, f0.acc_sload, i == 0);
      chk1({nm, "_clken"}, f0.acc_clken, 1'b1);
    end
    @(negedge clk);
    f0.in_valid = 1'b0; f0.in_last = 1'b0; f0.in_a = '0; f0.in_b = '0;
    #1;
    chk1({nm, "_drain_ready"}, f0.in_ready, 1'b0);
    chk1({nm, "_drain_valid"}, f0.res_valid, 1'b0);
    wait_result(nm, exp, 1'b0);
    if (hold > 0) begin
      f0.in_valid = 1'b1; f0.in_a = 32'h55; f0.in_b = 32'h66;
      repeat (hold) begin
        @(negedge clk); #1;
        chk1({nm, "_hold_valid"}, f0.res_valid, 1'b1);
        chkw({nm, "_hold_data"}, f0.res_data, exp);
        chk1({nm, "_hold_ready"}, f0.in_ready, 1'b0);
        chk1({nm, "_hold_sload"}, f0.acc_sload, 1'b0);
        chkw({nm, "_hold_acc_a"}, 64'(f0.acc_a), 64'd0);
      end
      @(negedge clk);
      f0.in_valid = 1'b0; f0.res_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk1({nm, "_release_valid"}, f0.res_valid, 1'b0);
    chk1({nm, "_idle_ready"}, f0.in_ready, 1'b1);
  endtask

  task automatic push(input string nm, input logic [W-1:0] a, input logic [W-1:0] b, input logic sload);
    @(negedge clk);
    f0.in_valid = 1'b1; f0.in_a = a; f0.in_b = b;
    #1;
    chk1({nm, "_sload"}, f0.acc_sload, sload);
  endtask

  task automatic no_result(input string nm);
    int seen = 0;
    repeat (LAT + 3) begin
      @(negedge clk); #1;
      if (f0.res_valid) seen++;
    end
    chkw({nm, "_no_result"}, 64'(seen), 64'd0);
  endtask

  task automatic pulse_reset(input string nm);
    @(negedge clk);
    rst = 1'b1; f0.in_valid = 1'b1; f0.in_a = 32'hAA; f0.in_b = 32'hBB;
    #1;
    chk1({nm, "_rst_ready"}, f0.in_ready, 1'b0);
    chk1({nm, "_rst_clken"}, f0.acc_clken, 1'b0);
    chk1({nm, "_rst_sload"}, f0.acc_sload, 1'b0);
    chkw({nm, "_rst_acc_a"}, 64'(f0.acc_a), 64'd0);
    @(negedge clk);
    chk1({nm, "_rst_valid"}, f0.res_valid, 1'b0);
    rst = 1'b0; f0.in_valid = 1'b0;
  endtask

  vec_t tbl [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_w_t va, vb;
    int gap, hold, lidx;
    f0.in_valid = 1'b0; f0.in_last = 1'b0; f0.in_a = '0; f0.in_b = '0; f0.res_ready = 1'b1;
    f1.in_valid = 1'b0; f1.in_last = 1'b0; f1.in_a = '0; f1.in_b = '0; f1.res_ready = 1'b1;

    tbl[0] = '{{32'd4, 32'd3, 32'd2, 32'd1}, {4{32'd1}}, 0, 0, -1, 64'd10};
    tbl[1] = '{{32'd4, 32'd3, 32'd2, 32'd1}, {4{32'd1}}, 1, 0, -1, 64'd10};
    tbl[2] = '{{32'd4, 32'd3, 32'd2, 32'd1}, {4{32'd1}}, 0, 5, -1, 64'd10};
    tbl[3] = '{{4{32'd0}}, {32'd9, 32'd8, 32'd7, 32'd6}, 2, 1, -1, 64'd0};
    tbl[4] = '{{4{32'hFFFF_FFFF}}, {4{32'hFFFF_FFFF}}, 0, 0, -1, 64'hFFFF_FFF8_0000_0004};
    tbl[5] = '{{32'd0, 32'd0, 32'd0, 32'h1_0000}, {32'd0, 32'd0, 32'd0, 32'h1_0000}, 1, 2, -1, 64'h1_0000_0000};
    tbl[6] = '{{32'd5, 32'd4, 32'd3, 32'd2}, {4{32'd1}}, 0, 0, 1, LAST_EN ? 64'd5 : 64'd14};

    // Reset state, with in_valid held high to expose any acceptance during reset
    f0.in_valid = 1'b1; f0.in_a = 32'h11; f0.in_b = 32'h22;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk1("reset_in_ready", f0.in_ready, 1'b0);
    chk1("reset_clken", f0.acc_clken, 1'b0);
    chk1("reset_sload", f0.acc_sload, 1'b0);
    chk1("reset_res_valid", f0.res_valid, 1'b0);
    chkw("reset_res_data", f0.res_data, 64'd0);
    chkw("reset_acc_a", 64'(f0.acc_a), 64'd0);
    @(negedge clk);
    rst = 1'b0; f0.in_valid = 1'b0; f0.in_a = '0; f0.in_b = '0;

    for (int t = 0; t < 7; t++)
      run_vec($sformatf("vec%0d", t), tbl[t].a, tbl[t].b, tbl[t].gap, tbl[t].hold,
              tbl[t].last_idx, tbl[t].exp);

    // Reset after the second transfer abandons the vector
    push("midvec0", 32'd9, 32'd9, 1'b1);
    push("midvec1", 32'd9, 32'd9, 1'b0);
    pulse_reset("midvec");
    no_result("midvec");
    run_vec("after_midvec", {4{32'd5}}, {4{32'd1}}, 0, 0, -1, 64'd20);

    // Reset during DRAIN abandons the result
    for (int i = 0; i < LEN; i++) push($sformatf("middrain%0d", i), 32'd3, 32'd3, i == 0);
    pulse_reset("middrain");
    no_result("middrain");
    run_vec("after_middrain", {32'd4, 32'd3, 32'd2, 32'd1}, {4{32'd1}}, 1, 0, -1, 64'd10);

    // Single-element vectors go straight from IDLE to DRAIN
    @(negedge clk);
    f1.in_valid = 1'b1; f1.in_a = 32'd7; f1.in_b = 32'd3;
    #1;
    chk1("len1_ready", f1.in_ready, 1'b1);
    chk1("len1_sload", f1.acc_sload, 1'b1);
    chkw("len1_acc_a", 64'(f1.acc_a), 64'd7);
    @(negedge clk);
    f1.in_valid = 1'b0;
    #1;
    chk1("len1_drain_ready", f1.in_ready, 1'b0);
    wait_result("len1", 64'd21, 1'b1);
    @(posedge clk); #1;
    chk1("len1_release", f1.res_valid, 1'b0);

    // Randomized vectors against the dot-product reference
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < LEN; i++) begin
        va[i] = (r % 2 == 0) ? $urandom : W'($urandom_range(0, 1000));
        vb[i] = (r % 2 == 0) ? $urandom : W'($urandom_range(0, 1000));
      end
      gap  = int'($urandom_range(0, 2));
      hold = int'($urandom_range(0, 3));
      lidx = int'($urandom_range(0, LEN)) - 1;
      run_vec($sformatf("rand%0d", r), va, vb, gap, hold, lidx, dot(va, vb, n_elems(lidx)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
